serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 128 ++++++++++++
 tb/tb_serial_adder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-add per clock, LSB first, single carry flop.
// Reports sum, unsigned carry-out and signed overflow, all registered.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-2:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] acc_ext;

    always_comb begin
        fa_s    = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        fa_c    = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
        // Accumulator keeps only the low WIDTH-1 bits; the final sum bit joins on the last add.
        acc_ext = {fa_s, acc_q};

        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = c_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                carry_d = fa_c;
                acc_d   = acc_ext[WIDTH-1:1];
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                if (cnt_q == LAST_BIT) begin
                    sum_d   = acc_ext;
                    c_out_d = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    busy_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 instance plus a WIDTH=2 smoke instance.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, c_in;
    logic [7:0] a, b;
    logic       busy, done, c_out, ovf;
    logic [7:0] sum;

    logic       start2, c_in2;
    logic [1:0] a2, b2;
    logic       busy2, done2, c_out2, ovf2;
    logic [1:0] sum2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
        .busy(busy), .done(done), .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .c_in(c_in2),
        .busy(busy2), .done(done2), .sum(sum2), .c_out(c_out2), .ovf(ovf2)
    );

    // Pulses start for one cycle and waits (bounded) for done; lat counts edges from the start edge.
    task automatic run_op(input logic [7:0] ra, input logic [7:0] rb, input logic rc,
                          output int lat, output bit busy_ok);
        @(negedge clk);
        a = ra; b = rb; c_in = rc; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 8'hxx; b = 8'hxx;
        lat = 1; busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 30) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL reset_ctrl got=%b want=00", {busy, done}); end
        total++; if ({sum, c_out, ovf} !== 10'h000) begin bad++; $display("FAIL reset_data got=%h want=000", {sum, c_out, ovf}); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL idle_ctrl got=%b want=00", {busy, done}); end
    endtask

    task automatic test_basic();
        int lat; bit bok;
        run_op(8'h35, 8'h4A, 1'b0, lat, bok);
        total++; if (lat !== 9) begin bad++; $display("FAIL basic_latency got=%0d want=9", lat); end
        total++; if (bok !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", bok); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b want=0", busy); end
        total++; if (sum !== 8'h7F) begin bad++; $display("FAIL basic_sum got=%h want=7f", sum); end
        total++; if ({c_out, ovf} !== 2'b00) begin bad++; $display("FAIL basic_flags got=%b want=00", {c_out, ovf}); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b want=0", done); end
        total++; if (sum !== 8'h7F) begin bad++; $display("FAIL basic_sum_hold got=%h want=7f", sum); end
    endtask

    task automatic test_carry();
        logic [7:0] va [4] = '{8'hFF, 8'h7F, 8'h80, 8'hFF};
        logic [7:0] vb [4] = '{8'h01, 8'h01, 8'h80, 8'hFF};
        logic       vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] es [4] = '{8'h00, 8'h80, 8'h00, 8'hFF};
        logic [1:0] ef [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
        int lat; bit bok;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vc[i], lat, bok);
            total++; if (lat !== 9) begin bad++; $display("FAIL carry_latency[%0d] got=%0d want=9", i, lat); end
            total++; if (sum !== es[i]) begin bad++; $display("FAIL carry_sum[%0d] got=%h want=%h", i, sum, es[i]); end
            total++; if ({c_out, ovf} !== ef[i]) begin bad++; $display("FAIL carry_flags[%0d] got=%b want=%b", i, {c_out, ovf}, ef[i]); end
        end
    endtask

    task automatic test_start_during_run();
        int lat; bit bok; int extra;
        @(negedge clk);
        a = 8'h10; b = 8'h20; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1; bok = 1'b1;
        while (done !== 1'b1 && lat < 30) begin
            if (busy !== 1'b1) bok = 1'b0;
            if (lat == 3) begin start = 1'b1; a = 8'hAA; b = 8'h55; c_in = 1'b1; end
            else start = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        total++; if (lat !== 9) begin bad++; $display("FAIL sdr_latency got=%0d want=9", lat); end
        total++; if (bok !== 1'b1) begin bad++; $display("FAIL sdr_busy got=%b want=1", bok); end
        total++; if (sum !== 8'h30) begin bad++; $display("FAIL sdr_sum got=%h want=30", sum); end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL sdr_no_second_op got=%0d want=0", extra); end
    endtask

    task automatic test_reset_mid();
        int lat; bit bok; int extra;
        @(negedge clk);
        a = 8'h12; b = 8'h34; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 4; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL rstmid_ctrl got=%b want=00", {busy, done}); end
        total++; if ({sum, c_out, ovf} !== 10'h000) begin bad++; $display("FAIL rstmid_data got=%h want=000", {sum, c_out, ovf}); end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=0", extra); end
        run_op(8'h01, 8'h02, 1'b0, lat, bok);
        total++; if (lat !== 9) begin bad++; $display("FAIL rstmid_latency got=%0d want=9", lat); end
        total++; if (sum !== 8'h03) begin bad++; $display("FAIL rstmid_sum got=%h want=03", sum); end
    endtask

    task automatic test_back_to_back();
        int edges; int first_done; int second_done;
        @(negedge clk);
        a = 8'h0F; b = 8'h01; c_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 1; first_done = 0; second_done = 0;
        while (second_done == 0 && edges < 40) begin
            if (done === 1'b1 && first_done == 0) begin
                first_done = edges;
                total++; if (sum !== 8'h10) begin bad++; $display("FAIL b2b_sum1 got=%h want=10", sum); end
                a = 8'h20; b = 8'h22; c_in = 1'b0; start = 1'b1;
            end else if (done === 1'b1) begin
                second_done = edges;
            end else begin
                start = 1'b0;
                if (edges == first_done + 1 && first_done != 0) begin
                    total++; if ({busy, sum} !== {1'b1, 8'h10}) begin bad++; $display("FAIL b2b_run_hold got=%h want=110", {busy, sum}); end
                end
            end
            if (second_done == 0) begin
                @(negedge clk);
                edges++;
            end
        end
        start = 1'b0;
        total++; if (first_done !== 9) begin bad++; $display("FAIL b2b_done1 got=%0d want=9", first_done); end
        total++; if (second_done !== 18) begin bad++; $display("FAIL b2b_done2 got=%0d want=18", second_done); end
        total++; if ({sum, c_out, ovf} !== {8'h42, 2'b00}) begin bad++; $display("FAIL b2b_result2 got=%h want=108", {sum, c_out, ovf}); end
    endtask

    task automatic test_width2();
        int lat;
        @(negedge clk);
        a2 = 2'h3; b2 = 2'h1; c_in2 = 1'b0; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = 1;
        while (done2 !== 1'b1 && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        total++; if (lat !== 3) begin bad++; $display("FAIL w2_latency got=%0d want=3", lat); end
        total++; if ({sum2, c_out2, ovf2} !== 4'b0010) begin bad++; $display("FAIL w2_result got=%b want=0010", {sum2, c_out2, ovf2}); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; c_in2 = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_start_during_run();
        test_reset_mid();
        test_back_to_back();
        test_width2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule
